// File: rtl/ysyx_25040101_csr_seq_pkg.sv
// ysyx_25040101_csr_seq_pkg: shared states, CSR addresses, mstatus fields and Zicsr op codes
package ysyx_25040101_csr_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CSR_RMW, S_T_EPC, S_T_CAUSE, S_T_STAT, S_T_VEC, S_R_STAT, S_R_EPC, S_DONE
  } state_t;
  typedef enum logic [1:0] {C_NONE, C_CSR, C_ECALL, C_MRET} cls_t;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam int MS_MIE = 3;
  localparam int MS_MPIE = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;
endpackage

// File: rtl/ysyx_25040101_csr_alu.sv
// ysyx_25040101_csr_alu: Zicsr read-modify-write result and mstatus trap/return rewrite
module ysyx_25040101_csr_alu
  import ysyx_25040101_csr_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] rmw,
  output logic [XLEN-1:0] trap_status,
  output logic [XLEN-1:0] ret_status
);
  always_comb begin
    rmw = op == OP_RW ? operand : op == OP_RS ? rdata | operand : rdata & ~operand;
    trap_status = rdata;
    trap_status[MS_MPIE] = rdata[MS_MIE];
    trap_status[MS_MIE] = 1'b0;
    trap_status[MS_MPP_HI:MS_MPP_LO] = 2'b11;
    ret_status = rdata;
    ret_status[MS_MIE] = rdata[MS_MPIE];
    ret_status[MS_MPIE] = 1'b1;
    ret_status[MS_MPP_HI:MS_MPP_LO] = 2'b11;
  end
endmodule

// File: rtl/ysyx_25040101_csr_seq.sv
// ysyx_25040101_csr_seq: sequences Zicsr/ecall/mret into single-port CSR accesses
module ysyx_25040101_csr_seq
  import ysyx_25040101_csr_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MCAUSE_ECALL = 32'd11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            is_ecall_i,
  input  logic            is_mret_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_index_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic            wr_suppress_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [11:0]     csr_index_o,
  output logic            csr_wen_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            done_o,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);
  state_t state;
  cls_t cls;
  logic [1:0] op_q;
  logic [11:0] index_q;
  logic [XLEN-1:0] operand_q, pc_q, old_q, target_q, rmw, trap_status, ret_status;
  logic suppress_q;
  ysyx_25040101_csr_alu #(.XLEN(XLEN)) u_alu (
    .op(op_q), .rdata(csr_rdata_i), .operand(operand_q),
    .rmw(rmw), .trap_status(trap_status), .ret_status(ret_status)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cls <= C_NONE;
      op_q <= OP_NONE;
      index_q <= '0;
      operand_q <= '0;
      suppress_q <= 1'b0;
      pc_q <= '0;
      old_q <= '0;
      target_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid_i) begin
          cls <= is_ecall_i ? C_ECALL : is_mret_i ? C_MRET : csr_op_i != OP_NONE ? C_CSR : C_NONE;
          state <= is_ecall_i ? S_T_EPC : is_mret_i ? S_R_STAT : csr_op_i != OP_NONE ? S_CSR_RMW : S_DONE;
          op_q <= csr_op_i;
          index_q <= csr_index_i;
          operand_q <= operand_i;
          suppress_q <= wr_suppress_i;
          pc_q <= pc_i;
          old_q <= '0;
          target_q <= '0;
        end
        S_CSR_RMW: begin
          old_q <= csr_rdata_i;
          state <= S_DONE;
        end
        S_T_EPC: state <= S_T_CAUSE;
        S_T_CAUSE: state <= S_T_STAT;
        S_T_STAT: state <= S_T_VEC;
        S_T_VEC: begin
          target_q <= {csr_rdata_i[XLEN-1:2], 2'b00};
          state <= S_DONE;
        end
        S_R_STAT: state <= S_R_EPC;
        S_R_EPC: begin
          target_q <= {csr_rdata_i[XLEN-1:2], 2'b00};
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign in_ready_o = state == S_IDLE;
  assign done_o = state == S_DONE;
  assign redirect_o = done_o && (cls == C_ECALL || cls == C_MRET);
  assign rd_wdata_o = done_o && cls == C_CSR ? old_q : '0;
  assign redirect_pc_o = redirect_o ? target_q : '0;
  assign csr_index_o = state == S_CSR_RMW ? index_q :
                       state inside {S_T_STAT, S_R_STAT} ? CSR_MSTATUS :
                       state == S_T_VEC ? CSR_MTVEC :
                       state inside {S_T_EPC, S_R_EPC} ? CSR_MEPC :
                       state == S_T_CAUSE ? CSR_MCAUSE : 12'h0;
  // a write in the cycle rst is seen would be a partial sequence, so it is held off
  assign csr_wen_o = !rst && (state == S_CSR_RMW ? !(suppress_q && op_q != OP_RW) :
                              state inside {S_T_EPC, S_T_CAUSE, S_T_STAT, S_R_STAT});
  assign csr_wdata_o = state == S_CSR_RMW ? rmw :
                       state == S_T_EPC ? pc_q :
                       state == S_T_CAUSE ? MCAUSE_ECALL :
                       state == S_T_STAT ? trap_status :
                       state == S_R_STAT ? ret_status : '0;
endmodule

// File: tb/tb_ysyx_25040101_csr_seq.sv
// tb_ysyx_25040101_csr_seq: directed scoreboard bench with a behavioural CSR file
module tb_ysyx_25040101_csr_seq;
  typedef struct {int cyc; logic [11:0] idx; logic [31:0] data;} wr_t;
  typedef struct {int cyc; logic [31:0] rd; logic redir; logic [31:0] pc;} res_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, is_ecall = 1'b0, is_mret = 1'b0, wr_suppress = 1'b0;
  logic [1:0] csr_op = 2'b00;
  logic [11:0] csr_index = 12'h0, csr_index_o;
  logic [31:0] operand = 0, pc = 0, csr_wdata, csr_rdata, rd_wdata, redirect_pc;
  logic csr_wen, done, redirect;
  logic poke = 1'b0;
  logic [11:0] poke_idx = 12'h0;
  logic [31:0] poke_val = 0;
  logic [31:0] m_status, m_tvec, m_epc, m_cause;
  logic [11:0] wi;
  logic [31:0] wd;
  wr_t wq[$];
  res_t rq[$];
  int checks = 0, fails = 0;

  ysyx_25040101_csr_seq dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .is_ecall_i(is_ecall), .is_mret_i(is_mret), .csr_op_i(csr_op), .csr_index_i(csr_index),
    .operand_i(operand), .wr_suppress_i(wr_suppress), .pc_i(pc),
    .csr_index_o(csr_index_o), .csr_wen_o(csr_wen), .csr_wdata_o(csr_wdata), .csr_rdata_i(csr_rdata),
    .done_o(done), .rd_wdata_o(rd_wdata), .redirect_o(redirect), .redirect_pc_o(redirect_pc)
  );

  always #5 clk = ~clk;

  assign wi = poke ? poke_idx : csr_index_o;
  assign wd = poke ? poke_val : csr_wdata;
  always @(posedge clk)
    if (poke || csr_wen)
      case (wi)
        12'h300: m_status <= wd;
        12'h305: m_tvec <= wd;
        12'h341: m_epc <= wd;
        12'h342: m_cause <= wd;
        default: ;
      endcase
  always_comb
    case (csr_index_o)
      12'h300: csr_rdata = m_status;
      12'h305: csr_rdata = m_tvec;
      12'h341: csr_rdata = m_epc;
      12'h342: csr_rdata = m_cause;
      default: csr_rdata = 32'h0;
    endcase

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_csr(input logic [11:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke = 1'b1; poke_idx = idx; poke_val = val;
    @(posedge clk);
    #1 poke = 1'b0;
  endtask

  task automatic exp_wr(input int cyc, input logic [11:0] idx, input logic [31:0] data);
    wr_t w;
    w.cyc = cyc; w.idx = idx; w.data = data;
    wq.push_back(w);
  endtask

  task automatic exp_res(input int cyc, input logic [31:0] rd, input logic redir, input logic [31:0] tpc);
    res_t r;
    r.cyc = cyc; r.rd = rd; r.redir = redir; r.pc = tpc;
    rq.push_back(r);
  endtask

  task automatic drive(input logic ec, input logic mr, input logic [1:0] op, input logic [11:0] idx,
                       input logic [31:0] opnd, input logic sup, input logic [31:0] ipc);
    @(negedge clk);
    chk("ready_idle", {31'b0, in_ready}, 1);
    in_valid = 1'b1; is_ecall = ec; is_mret = mr; csr_op = op; csr_index = idx;
    operand = opnd; wr_suppress = sup; pc = ipc;
    @(posedge clk);
    #1 in_valid = 1'b0; is_ecall = 1'($urandom); is_mret = 1'($urandom); csr_op = 2'($urandom);
    csr_index = 12'($urandom); operand = $urandom; wr_suppress = 1'($urandom); pc = $urandom;
  endtask

  task automatic run(input logic ec, input logic mr, input logic [1:0] op, input logic [11:0] idx,
                     input logic [31:0] opnd, input logic sup, input logic [31:0] ipc);
    bit got, ew;
    wr_t w;
    res_t r;
    drive(ec, mr, op, idx, opnd, sup, ipc);
    got = 0;
    for (int cyc = 1; cyc <= 12 && !got; cyc++) begin
      @(negedge clk);
      ew = wq.size() > 0 && wq[0].cyc == cyc;
      chk("wen", {31'b0, csr_wen}, {31'b0, ew});
      if (ew && csr_wen) begin
        w = wq.pop_front();
        chk("wr_index", {20'b0, csr_index_o}, {20'b0, w.idx});
        chk("wr_data", csr_wdata, w.data);
      end
      chk("busy_ready", {31'b0, in_ready}, 0);
      if (done) begin
        got = 1;
        if (rq.size() == 0) chk("spurious_done", {31'b0, done}, 0);
        else begin
          r = rq.pop_front();
          chk("done_cycle", cyc, r.cyc);
          chk("rd_wdata", rd_wdata, r.rd);
          chk("redirect", {31'b0, redirect}, {31'b0, r.redir});
          chk("redirect_pc", redirect_pc, r.pc);
        end
      end
    end
    if (!got) chk("done_timeout", {31'b0, done}, 1);
    chk("writes_left", wq.size(), 0);
    wq.delete();
    rq.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'b0, in_ready}, 1);
    chk("rst_wen", {31'b0, csr_wen}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_redirect", {31'b0, redirect}, 0);
    chk("rst_rd_wdata", rd_wdata, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_index", {20'b0, csr_index_o}, 0);
    chk("rst_wdata", csr_wdata, 0);
    set_csr(12'h300, 32'h8);
    set_csr(12'h305, 32'h80000100);
    set_csr(12'h341, 32'h0);
    set_csr(12'h342, 32'h0);
    // RS on mstatus
    exp_wr(1, 12'h300, 32'h88);
    exp_res(2, 32'h8, 0, 0);
    run(0, 0, 2'b10, 12'h300, 32'h80, 0, 0);
    // RC with suppressed write on mtvec
    exp_res(2, 32'h80000100, 0, 0);
    run(0, 0, 2'b11, 12'h305, 32'h5, 1, 0);
    // RW to an unimplemented CSR: write issued, old value reads as 0
    exp_wr(1, 12'h340, 32'h1234);
    exp_res(2, 32'h0, 0, 0);
    run(0, 0, 2'b01, 12'h340, 32'h1234, 0, 0);
    // RC without suppression on mepc
    set_csr(12'h341, 32'hff);
    exp_wr(1, 12'h341, 32'hf0);
    exp_res(2, 32'hff, 0, 0);
    run(0, 0, 2'b11, 12'h341, 32'h0f, 0, 0);
    // ecall
    set_csr(12'h300, 32'h8);
    set_csr(12'h305, 32'h80000103);
    exp_wr(1, 12'h341, 32'h80000040);
    exp_wr(2, 12'h342, 32'd11);
    exp_wr(3, 12'h300, 32'h1880);
    exp_res(5, 32'h0, 1, 32'h80000100);
    run(1, 0, 2'b00, 12'h0, 32'h0, 0, 32'h80000040);
    // mret
    set_csr(12'h341, 32'h80000044);
    exp_wr(1, 12'h300, 32'h1888);
    exp_res(3, 32'h0, 1, 32'h80000044);
    run(0, 1, 2'b00, 12'h0, 32'h0, 0, 0);
    // ecall wins over a simultaneous RW
    exp_wr(1, 12'h341, 32'h80000080);
    exp_wr(2, 12'h342, 32'd11);
    exp_wr(3, 12'h300, 32'h1880);
    exp_res(5, 32'h0, 1, 32'h80000100);
    run(1, 0, 2'b01, 12'h340, 32'h5, 0, 32'h80000080);
    // no class set, back-to-back with the previous instruction
    exp_res(1, 32'h0, 0, 0);
    run(0, 0, 2'b00, 12'h300, 32'hffff, 0, 32'h1000);
    // reset while in T_CAUSE
    set_csr(12'h342, 32'h77);
    set_csr(12'h341, 32'h0);
    drive(1, 0, 2'b00, 12'h0, 32'h0, 0, 32'h80000200);
    @(negedge clk);
    chk("rst_seq_epc_wen", {31'b0, csr_wen}, 1);
    chk("rst_seq_epc_idx", {20'b0, csr_index_o}, 32'h341);
    @(negedge clk);
    chk("rst_seq_cause_idx", {20'b0, csr_index_o}, 32'h342);
    rst = 1'b1;
    #1;
    chk("rst_seq_wen_held", {31'b0, csr_wen}, 0);
    chk("rst_seq_done_c2", {31'b0, done}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_seq_ready", {31'b0, in_ready}, 1);
    chk("rst_seq_done", {31'b0, done}, 0);
    chk("rst_seq_redirect", {31'b0, redirect}, 0);
    chk("rst_seq_idle_wen", {31'b0, csr_wen}, 0);
    chk("rst_seq_mepc", m_epc, 32'h80000200);
    chk("rst_seq_mcause", m_cause, 32'h77);
    // recovery after reset: RS on mstatus (0x1880 from the last completed ecall)
    exp_wr(1, 12'h300, 32'h1888);
    exp_res(2, 32'h1880, 0, 0);
    run(0, 0, 2'b10, 12'h300, 32'h8, 0, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_25040101_csr_seq.md
# ysyx_25040101_csr_seq

Multi-cycle sequencer that owns the single read/write port of the machine-mode CSR register file. It accepts one system instruction at a time from the execute stage: Zicsr read-modify-write, `ecall` or `mret`. Each instruction is broken into CSR port accesses, one per cycle. The block returns the old CSR value for `rd`, and for trap entry/exit a PC redirect to the fetch stage.

## Interface
Parameters
- `XLEN`, 32, data width
- `MCAUSE_ECALL`, 32'd11, cause code written on `ecall`

Ports
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid_i`  in  1  instruction offered
- `in_ready_o`  out  1  sequencer can accept (IDLE only)
- `is_ecall_i` / `is_mret_i`  in  1 each  instruction class
- `csr_op_i`  in  2  00 none, 01 RW, 10 RS, 11 RC
- `csr_index_i`  in  12  target CSR for Zicsr ops
- `operand_i`  in  XLEN  rs1 value or zero-extended uimm
- `wr_suppress_i`  in  1  RS/RC with rs1/uimm = 0: no write
- `pc_i`  in  XLEN  PC of the instruction
- `csr_index_o`  out  12  CSR port address
- `csr_wen_o`  out  1  CSR port write enable
- `csr_wdata_o`  out  XLEN  CSR port write data
- `csr_rdata_i`  in  XLEN  CSR port read data, combinational from `csr_index_o`
- `done_o`  out  1  one-cycle completion pulse
- `rd_wdata_o`  out  XLEN  old CSR value, valid with `done_o`
- `redirect_o`  out  1  PC redirect, coincident with `done_o`
- `redirect_pc_o`  out  XLEN  redirect target

## Operation
- Accept when `in_valid_i && in_ready_o`. Latch all inputs. Decode priority: ecall > mret > csr_op. If no class is set, go straight to DONE.
- States: IDLE, CSR_RMW, T_EPC, T_CAUSE, T_STAT, T_VEC, R_STAT, R_EPC, DONE.
- CSR_RMW:
  - drive `csr_index_o` = latched index and latch `csr_rdata_i` as old.
  - new value: RW = operand; RS = old | operand; RC = old & ~operand.
  - `csr_wen_o` = !(suppress && op != RW).
  - then DONE.
- T_EPC: write 0x341 ← pc.
- T_CAUSE: write 0x342 ← MCAUSE_ECALL.
- T_STAT: read 0x300, then write it back with MPIE ← MIE, MIE ← 0, MPP ← 2'b11.
- T_VEC: read 0x305 with no write; latch target = {rdata[31:2], 2'b00} (direct mode only). Then DONE.
- R_STAT: read 0x300, then write it back with MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
- R_EPC: read 0x341; latch target = {rdata[31:2], 2'b00}. Then DONE.
- DONE:
  - `done_o` = 1.
  - `rd_wdata_o` = old value for CSR ops, 0 otherwise.
  - `redirect_o` = 1 for ecall/mret.
  - Next state IDLE.
- `csr_wen_o` is 0 in IDLE, DONE, T_VEC and R_EPC. `csr_index_o` is 0 in IDLE.

## Timing
- Cycle 0 is the accept edge. `done_o` is high in cycle 2 for a CSR op, cycle 5 for ecall, cycle 3 for mret, and cycle 1 for no-op.
- Back-to-back throughput: a new accept can occur in the cycle after DONE. `in_ready_o` is low in DONE.
- Reset:
  - takes effect at the next `clk` edge, including mid-sequence: state → IDLE, no partial completion, no `done_o`.
  - after reset: `in_ready_o`=1; `csr_wen_o`, `done_o`, `redirect_o` = 0; `rd_wdata_o`, `redirect_pc_o`, `csr_index_o`, `csr_wdata_o` = 0.
  - CSR writes already committed before reset stay committed.
- Inputs other than `in_valid_i` are ignored outside the accept cycle.
- Writes to read-only or unimplemented indices are issued anyway; the CSR file ignores them and reads return 0.

## Structure
- Shared package:
  - state enum.
  - CSR addresses: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342.
  - mstatus bit positions: MIE 3, MPIE 7, MPP 12:11.
  - `csr_op` encodings.
- One natural combinational sub-module, `ysyx_25040101_csr_alu`: computes the RW/RS/RC result and the mstatus trap/return rewrite.
- FSM and latches stay in the top.

## Test plan
- CSR RS: mstatus=0x8, operand 0x80 → cycle-1 write 0x88 to 0x300; cycle 2 `done_o`=1, `rd_wdata_o`=0x8, `redirect_o`=0.
- RC with `wr_suppress_i`=1 on 0x305 (mtvec=0x80000100) → `csr_wen_o` never high; `rd_wdata_o`=0x80000100.
- ecall, pc=0x80000040, mtvec=0x80000103, mstatus=0x8:
  - writes in order mepc=0x80000040, mcause=11, mstatus=0x1880.
  - cycle 5: `redirect_pc_o`=0x80000100, `done_o`=1.
- mret, mepc=0x80000044, mstatus=0x1880 → mstatus=0x1888; cycle 3 `redirect_pc_o`=0x80000044.
- ecall and csr_op=RW set together → trap sequence only; no Zicsr write.
- `rst` asserted in T_CAUSE → next cycle IDLE with `in_ready_o`=1; mepc already written, mcause untouched; no `done_o`.
